display_timings_gen: RTL
========================

Name: display_timings_gen

Overview:
- Parametrised successor to the fixed-width variable display timing generator in the DVI output path.
- Produces signed beam coordinates and sync/DE/frame/line strobes for the DVI encoder.
- Coordinate width and reset-time mode are parameters.
- New timing sets are accepted over a valid/ready handshake and applied atomically at the next frame boundary, so a frame never mixes two sets.
- All strobes are registered and aligned with the coordinates.

Parameters:
- CW, 16: coordinate/config width. Coordinates are signed CW; config fields are unsigned CW.
- DEF_H_RES, 640: reset-time horizontal active pixels.
- DEF_H_FP / DEF_H_SYNC / DEF_H_BP, 16 / 96 / 48: reset-time horizontal porches and sync.
- DEF_V_RES, 480: reset-time vertical active lines.
- DEF_V_FP / DEF_V_SYNC / DEF_V_BP, 10 / 2 / 33: reset-time vertical porches and sync.
- DEF_H_POL / DEF_V_POL, 0 / 0: reset-time sync polarity (0 neg, 1 pos).

Ports:
- i_pix_clk  in  1  pixel clock; the only clock.
- i_rst  in  1  synchronous, active-high reset.
- i_cfg_valid  in  1  config offer.
- o_cfg_ready  out  1  config slot free.
- i_h_res, i_h_fp, i_h_sync, i_h_bp  in  CW each  horizontal config.
- i_v_res, i_v_fp, i_v_sync, i_v_bp  in  CW each  vertical config.
- i_h_pol, i_v_pol  in  1 each  polarity config.
- o_cfg_applied  out  1  one-cycle pulse: pending set became active.
- o_hs, o_vs  out  1 each  sync, polarity applied.
- o_de  out  1  active video.
- o_frame  out  1  first pixel of frame (sx=h_sta, sy=v_sta).
- o_line  out  1  first pixel of every line (sx=h_sta).
- o_sx, o_sy  out  CW signed  beam position.

Behaviour:
- Active set derivation:
  - h_sta = -(h_fp+h_sync+h_bp); ha_end = h_res-1.
  - Vertical values derived the same way.
  - Derived values are registered on apply (and on reset), never combinational from the live inputs.
- Reset (i_rst high at a clock edge):
  - Active set loads DEF_*; pending slot is cleared.
  - o_sx=h_sta(DEF), o_sy=v_sta(DEF); o_cfg_ready=1; o_cfg_applied=0.
  - Strobes are computed for that position: o_frame=1, o_line=1, o_de=0, o_hs/o_vs inactive level.
  - A reset mid-frame or mid-handshake discards the pending set.
- Counting:
  - o_sx increments each cycle.
  - At sx=ha_end, sx wraps to h_sta; sy then increments, or wraps to v_sta when sy=va_end.
- Strobes are registered from next-state coordinates, so they coincide with o_sx/o_sy (latency 0 relative to coordinates).
  - o_de = sx>=0 && sy>=0.
  - hs true for sx in [h_sta+h_fp, h_sta+h_fp+h_sync-1]: exactly h_sync cycles per line.
  - vs true for sy in [v_sta+v_fp, v_sta+v_fp+v_sync-1]: exactly v_sync lines.
  - Polarity applies: output = pol ? true : ~true.
- Handshake:
  - Transfer occurs on i_cfg_valid && o_cfg_ready; the fields are captured into the pending slot and o_cfg_ready drops next cycle.
  - o_cfg_ready stays low while the slot is full.
- Apply:
  - Occurs on the end-of-frame cycle (sx=ha_end && sy=va_end) with the slot full.
  - Next cycle: active set is the new set, sx/sy = new h_sta/v_sta, o_cfg_applied=1, o_cfg_ready=1.
  - A transfer in the same cycle as end-of-frame is not applied until the following frame boundary.
- Range rule: h_fp+h_sync+h_bp and h_res must each be <= 2^(CW-1)-1, and likewise vertical. Out-of-range sets are undefined unless DTG_CFG_CHECK_EN.
- Zero fp or bp is legal. Sync width 0 means sync is never asserted.

Optional Feature:
- Macro: DTG_CFG_CHECK_EN.
- Defined:
  - Adds output o_cfg_err (1 bit).
  - A set with h_res=0, v_res=0, or any range-rule violation is consumed by the handshake but never stored.
  - o_cfg_err pulses 1 cycle after the transfer; the active set is unchanged.
  - o_cfg_err resets to 0.
- Undefined: port absent, no checking, every transfer is stored.

Decomposition:
- Package dtg_pkg: DEF_* default constants, the CW default, and the range-limit function/localparam.
- Sub-module dtg_axis_counter:
  - One axis: sta/end/sync-window compare, wrap, sync flag.
  - Instantiated twice; the vertical instance is enabled by the horizontal wrap.
- The top holds the pending/active sets, handshake and apply logic.

Test Plan:
- Reset defaults: release i_rst, run 420000 cycles → o_frame period 420000 (800x525); o_hs low 96 cycles per line; o_vs low 2 lines; o_de high 640x480 per frame.
- Mid-frame update: transfer 1280x720 (fp110/sync40/bp220, vfp5/vsync5/vbp20, pos pol) at sy=100 → current frame keeps 800-cycle lines; o_cfg_applied at the frame boundary; next frame 1650x750 with active-high syncs.
- Back-pressure: second i_cfg_valid while slot full → o_cfg_ready=0, value not captured until after apply; then captured and applied one frame later.
- Same-cycle boundary: transfer exactly on the end-of-frame cycle → not applied; frame runs with the old set; applied at the following boundary.
- Reset mid-operation: i_rst asserted at sx=300, sy=200 with slot full → next cycle sx=-160, sy=-45, o_cfg_ready=1, pending discarded, defaults active.
- DTG_CFG_CHECK_EN: transfer h_res=0 → o_cfg_err pulse, no o_cfg_applied, timing unchanged; transfer h_fp=h_sync=h_bp=20000 with CW=16 → o_cfg_err.

Source files
------------

// File: rtl/dtg_pkg.sv
// Shared constants for the display timing generator: default 640x480@60 timing,
// default coordinate width and the configuration range limit.
package dtg_pkg;

  localparam int DTG_CW = 16;

  localparam int DTG_DEF_H_RES  = 640;
  localparam int DTG_DEF_H_FP   = 16;
  localparam int DTG_DEF_H_SYNC = 96;
  localparam int DTG_DEF_H_BP   = 48;
  localparam int DTG_DEF_V_RES  = 480;
  localparam int DTG_DEF_V_FP   = 10;
  localparam int DTG_DEF_V_SYNC = 2;
  localparam int DTG_DEF_V_BP   = 33;
  localparam int DTG_DEF_H_POL  = 0;
  localparam int DTG_DEF_V_POL  = 0;

  // True when v fits the positive range of a signed cw-bit coordinate.
  function automatic logic dtg_in_range(input logic [31:0] v, input int cw);
    return v <= ((32'd1 << (cw - 1)) - 32'd1);
  endfunction

endpackage

// File: rtl/dtg_axis_counter.sv
// One beam axis: position counter with wrap to the start value and a registered,
// polarity-corrected sync flag computed from the next-cycle position.
module dtg_axis_counter #(
  parameter int                     CW       = 16,
  parameter logic signed [CW-1:0]   RST_POS  = '0,
  parameter logic                   RST_SYNC = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 step_i,
  input  logic signed [CW-1:0] cur_end_i,
  input  logic signed [CW-1:0] nxt_sta_i,
  input  logic signed [CW-1:0] nxt_sbeg_i,
  input  logic signed [CW-1:0] nxt_send_i,
  input  logic                 nxt_pol_i,
  output logic signed [CW-1:0] pos_o,
  output logic                 wrap_o,
  output logic                 nxt_at_sta_o,
  output logic                 nxt_nneg_o,
  output logic                 sync_o
);

  localparam logic signed [CW-1:0] ONE = 1;

  logic signed [CW-1:0] pos_q, pos_d;
  logic                 sync_q, sync_d;

  assign wrap_o = (pos_q == cur_end_i);

  // Everything is evaluated against the set that is in force next cycle, so a
  // set switched in at the frame boundary already governs the first position.
  always_comb begin
    pos_d = pos_q;
    if (step_i) begin
      pos_d = wrap_o ? nxt_sta_i : pos_q + ONE;
    end
    sync_d = ((pos_d >= nxt_sbeg_i) && (pos_d <= nxt_send_i)) ? nxt_pol_i : ~nxt_pol_i;
  end

  assign nxt_at_sta_o = (pos_d == nxt_sta_i);
  assign nxt_nneg_o   = ~pos_d[CW-1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pos_q  <= RST_POS;
      sync_q <= RST_SYNC;
    end else begin
      pos_q  <= pos_d;
      sync_q <= sync_d;
    end
  end

  assign pos_o  = pos_q;
  assign sync_o = sync_q;

endmodule

// File: rtl/display_timings_gen.sv
// Parametrised display timing generator with a one-deep config slot applied at the
// frame boundary. Optional input checking is enabled with DTG_CFG_CHECK_EN.
module display_timings_gen
  import dtg_pkg::*;
#(
  parameter int CW         = DTG_CW,
  parameter int DEF_H_RES  = DTG_DEF_H_RES,
  parameter int DEF_H_FP   = DTG_DEF_H_FP,
  parameter int DEF_H_SYNC = DTG_DEF_H_SYNC,
  parameter int DEF_H_BP   = DTG_DEF_H_BP,
  parameter int DEF_V_RES  = DTG_DEF_V_RES,
  parameter int DEF_V_FP   = DTG_DEF_V_FP,
  parameter int DEF_V_SYNC = DTG_DEF_V_SYNC,
  parameter int DEF_V_BP   = DTG_DEF_V_BP,
  parameter int DEF_H_POL  = DTG_DEF_H_POL,
  parameter int DEF_V_POL  = DTG_DEF_V_POL
) (
  input  logic                 i_pix_clk,
  input  logic                 i_rst,
  input  logic                 i_cfg_valid,
  output logic                 o_cfg_ready,
  input  logic [CW-1:0]        i_h_res,
  input  logic [CW-1:0]        i_h_fp,
  input  logic [CW-1:0]        i_h_sync,
  input  logic [CW-1:0]        i_h_bp,
  input  logic [CW-1:0]        i_v_res,
  input  logic [CW-1:0]        i_v_fp,
  input  logic [CW-1:0]        i_v_sync,
  input  logic [CW-1:0]        i_v_bp,
  input  logic                 i_h_pol,
  input  logic                 i_v_pol,
  output logic                 o_cfg_applied,
`ifdef DTG_CFG_CHECK_EN
  output logic                 o_cfg_err,
`endif
  output logic                 o_hs,
  output logic                 o_vs,
  output logic                 o_de,
  output logic                 o_frame,
  output logic                 o_line,
  output logic signed [CW-1:0] o_sx,
  output logic signed [CW-1:0] o_sy
);

  localparam logic [CW-1:0] ONE = 1;

  typedef struct packed {
    logic signed [CW-1:0] sta;
    logic signed [CW-1:0] aend;
    logic signed [CW-1:0] sbeg;
    logic signed [CW-1:0] send;
    logic                 pol;
  } axis_set_t;

  // A zero sync width yields send = sbeg-1, an empty window.
  function automatic axis_set_t derive(input logic [CW-1:0] res, input logic [CW-1:0] fp,
                                       input logic [CW-1:0] sync, input logic [CW-1:0] bp,
                                       input logic pol);
    axis_set_t s;
    s.sta  = -$signed(fp + sync + bp);
    s.aend = $signed(res - ONE);
    s.sbeg = s.sta + $signed(fp);
    s.send = s.sbeg + $signed(sync) - $signed(ONE);
    s.pol  = pol;
    return s;
  endfunction

  localparam axis_set_t DEF_H = derive(CW'(DEF_H_RES), CW'(DEF_H_FP), CW'(DEF_H_SYNC),
                                       CW'(DEF_H_BP), 1'(DEF_H_POL));
  localparam axis_set_t DEF_V = derive(CW'(DEF_V_RES), CW'(DEF_V_FP), CW'(DEF_V_SYNC),
                                       CW'(DEF_V_BP), 1'(DEF_V_POL));

  axis_set_t act_h_q, act_v_q, pend_h_q, pend_v_q;
  axis_set_t nxt_h, nxt_v;
  logic      pend_vld_q;
  logic      applied_q, de_q, line_q, frame_q;
  logic      xfer, store, apply, eof;
  logic      h_wrap, v_wrap, h_at_sta, v_at_sta, h_nneg, v_nneg;

  assign xfer  = i_cfg_valid && !pend_vld_q;
  assign eof   = h_wrap && v_wrap;
  assign apply = eof && pend_vld_q;
  assign nxt_h = apply ? pend_h_q : act_h_q;
  assign nxt_v = apply ? pend_v_q : act_v_q;

`ifdef DTG_CFG_CHECK_EN
  logic [CW+1:0] h_sum, v_sum;
  logic          cfg_bad;
  logic          err_q;

  assign h_sum = (CW+2)'(i_h_fp) + (CW+2)'(i_h_sync) + (CW+2)'(i_h_bp);
  assign v_sum = (CW+2)'(i_v_fp) + (CW+2)'(i_v_sync) + (CW+2)'(i_v_bp);
  assign cfg_bad = (i_h_res == '0) || (i_v_res == '0) ||
                   !dtg_in_range(32'(h_sum), CW) || !dtg_in_range(32'(i_h_res), CW) ||
                   !dtg_in_range(32'(v_sum), CW) || !dtg_in_range(32'(i_v_res), CW);
  assign store = xfer && !cfg_bad;

  always_ff @(posedge i_pix_clk) begin
    if (i_rst) err_q <= 1'b0;
    else       err_q <= xfer && cfg_bad;
  end
  assign o_cfg_err = err_q;
`else
  assign store = xfer;
`endif

  // Slot, active set and handshake; store and apply are mutually exclusive.
  always_ff @(posedge i_pix_clk) begin
    if (i_rst) begin
      act_h_q    <= DEF_H;
      act_v_q    <= DEF_V;
      pend_vld_q <= 1'b0;
      applied_q  <= 1'b0;
    end else begin
      if (apply) begin
        act_h_q <= pend_h_q;
        act_v_q <= pend_v_q;
      end
      pend_vld_q <= store | (pend_vld_q & ~apply);
      applied_q  <= apply;
    end
  end

  always_ff @(posedge i_pix_clk) begin
    if (store) begin
      pend_h_q <= derive(i_h_res, i_h_fp, i_h_sync, i_h_bp, i_h_pol);
      pend_v_q <= derive(i_v_res, i_v_fp, i_v_sync, i_v_bp, i_v_pol);
    end
  end

  dtg_axis_counter #(.CW(CW), .RST_POS(DEF_H.sta), .RST_SYNC(~DEF_H.pol)) u_h (
    .clk_i        (i_pix_clk),
    .rst_i        (i_rst),
    .step_i       (1'b1),
    .cur_end_i    (act_h_q.aend),
    .nxt_sta_i    (nxt_h.sta),
    .nxt_sbeg_i   (nxt_h.sbeg),
    .nxt_send_i   (nxt_h.send),
    .nxt_pol_i    (nxt_h.pol),
    .pos_o        (o_sx),
    .wrap_o       (h_wrap),
    .nxt_at_sta_o (h_at_sta),
    .nxt_nneg_o   (h_nneg),
    .sync_o       (o_hs)
  );

  dtg_axis_counter #(.CW(CW), .RST_POS(DEF_V.sta), .RST_SYNC(~DEF_V.pol)) u_v (
    .clk_i        (i_pix_clk),
    .rst_i        (i_rst),
    .step_i       (h_wrap),
    .cur_end_i    (act_v_q.aend),
    .nxt_sta_i    (nxt_v.sta),
    .nxt_sbeg_i   (nxt_v.sbeg),
    .nxt_send_i   (nxt_v.send),
    .nxt_pol_i    (nxt_v.pol),
    .pos_o        (o_sy),
    .wrap_o       (v_wrap),
    .nxt_at_sta_o (v_at_sta),
    .nxt_nneg_o   (v_nneg),
    .sync_o       (o_vs)
  );

  // Strobes registered from next-state coordinates to line up with o_sx/o_sy.
  always_ff @(posedge i_pix_clk) begin
    if (i_rst) begin
      de_q    <= 1'b0;
      line_q  <= 1'b1;
      frame_q <= 1'b1;
    end else begin
      de_q    <= h_nneg && v_nneg;
      line_q  <= h_at_sta;
      frame_q <= h_at_sta && v_at_sta;
    end
  end

  assign o_de          = de_q;
  assign o_line        = line_q;
  assign o_frame       = frame_q;
  assign o_cfg_applied = applied_q;
  assign o_cfg_ready   = ~pend_vld_q;

endmodule
